// File: rtl/pwm_compare_dt_if.sv
// Purpose : bundles the carrier/shadow inputs and gate-command outputs of one PWM compare channel.
// Latency : n/a (wiring only).
// Backpressure: none; all signals are sampled or driven every clock.
//
// Ports (as seen from the compare stage, modport slave):
//   carrier   in  carrier value from the carrier generator
//   period    in  carrier period (same value fed to the generator)
//   compare   in  shadow compare value
//   deadtime  in  shadow dead-time, in clk cycles
//   pwm_onoff in  1 = channel enabled, 0 = outputs forced low
//   pwm_h     out high-side gate command
//   pwm_l     out low-side gate command
//   load_evt  out shadows copied to active registers this cycle
//   dt_active out a dead-time interval is counting
interface pwm_compare_dt_if #(
  parameter int WIDTH    = 16,
  parameter int DT_WIDTH = 10
);

  logic [WIDTH-1:0]    carrier;
  logic [WIDTH-1:0]    period;
  logic [WIDTH-1:0]    compare;
  logic [DT_WIDTH-1:0] deadtime;
  logic                pwm_onoff;
  logic                pwm_h;
  logic                pwm_l;
  logic                load_evt;
  logic                dt_active;

  // Carrier generator / register block side.
  modport master (
    output carrier,
    output period,
    output compare,
    output deadtime,
    output pwm_onoff,
    input  pwm_h,
    input  pwm_l,
    input  load_evt,
    input  dt_active
  );

  // Compare stage side.
  modport slave (
    input  carrier,
    input  period,
    input  compare,
    input  deadtime,
    input  pwm_onoff,
    output pwm_h,
    output pwm_l,
    output load_evt,
    output dt_active
  );

endinterface

// File: rtl/pwm_compare_dt.sv
// Purpose : per-channel compare stage turning the carrier into a complementary PWM pair with dead-time.
// Latency : gate outputs are registered, 1 cycle after the compare edge; load_evt is combinational.
// Backpressure: none; the stage consumes the carrier every cycle.
//
// Ports: clk (rising edge), reset (synchronous, active-high), bus (pwm_compare_dt_if.slave):
//   carrier/period/compare/deadtime/pwm_onoff in; pwm_h/pwm_l/load_evt/dt_active out.
// Optional build macro PWM_TOP_LOAD_EN: also reload the shadows when the carrier reaches
// period-1 (twice-per-period updates for an up-down carrier). Undefined: zero events only.
module pwm_compare_dt #(
  parameter int WIDTH    = 16,
  parameter int DT_WIDTH = 10
) (
  input  logic            clk,
  input  logic            reset,
  pwm_compare_dt_if.slave bus
);

  typedef enum logic [2:0] {
    ST_OFF     = 3'd0,
    ST_H_ON    = 3'd1,
    ST_L_ON    = 3'd2,
    ST_DT_TO_H = 3'd3,
    ST_DT_TO_L = 3'd4
  } state_e;

  state_e              state_q,     state_d;
  logic [WIDTH-1:0]    cmp_act_q,   cmp_act_d;
  logic [DT_WIDTH-1:0] dt_act_q,    dt_act_d;
  logic [WIDTH-1:0]    carrier_q,   carrier_d;
  logic [DT_WIDTH-1:0] dt_cnt_q,    dt_cnt_d;
  logic                from_off_q,  from_off_d;
  logic                pwm_h_q,     pwm_h_d;
  logic                pwm_l_q,     pwm_l_d;
  logic                dt_active_q, dt_active_d;

  logic                raw;
  logic                zero_evt;
  logic                top_evt;
  logic                load;
  logic                dt_done;
  logic [DT_WIDTH-1:0] dt_dec;

  // Reference edge: high while the carrier is below the active compare value.
  assign raw = (bus.carrier < cmp_act_q);

  // ---------------------------------------------------------------------------
  // Shadow -> active transfer
  // ---------------------------------------------------------------------------
`ifdef PWM_TOP_LOAD_EN
  logic [WIDTH-1:0] period_m1;
  assign period_m1 = bus.period - WIDTH'(1);
`else
  // period only matters for the top event; fold it away in this build.
  logic period_unused;
  assign period_unused = ^bus.period;
`endif

  always_comb begin
    carrier_d = bus.carrier;
    zero_evt  = (bus.carrier == '0) && (carrier_q != '0);
`ifdef PWM_TOP_LOAD_EN
    top_evt   = (bus.carrier >= period_m1) && (carrier_q < period_m1);
`else
    top_evt   = 1'b0;
`endif
    load      = bus.pwm_onoff && (zero_evt || top_evt);

    cmp_act_d = cmp_act_q;
    dt_act_d  = dt_act_q;
    // A disabled channel is transparent so it re-enables with current settings;
    // an enabled one only updates on a period boundary to avoid runt pulses.
    if (!bus.pwm_onoff || load) begin
      cmp_act_d = bus.compare;
      dt_act_d  = bus.deadtime;
    end
  end

  // ---------------------------------------------------------------------------
  // Gate FSM
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d    = state_q;
    dt_cnt_d   = dt_cnt_q;
    from_off_d = from_off_q;

    // dt_cnt holds the number of low cycles still to go including the current
    // one, so the interval ends on the cycle the counter would reach zero.
    dt_done = (dt_cnt_q <= DT_WIDTH'(1));
    dt_dec  = dt_done ? '0 : (dt_cnt_q - DT_WIDTH'(1));

    if (!bus.pwm_onoff) begin
      state_d    = ST_OFF;
      dt_cnt_d   = '0;
      from_off_d = 1'b0;
    end else begin
      unique case (state_q)
        ST_OFF: begin
          if (dt_act_q == '0) begin
            state_d    = raw ? ST_H_ON : ST_L_ON;
            from_off_d = 1'b0;
          end else begin
            state_d    = raw ? ST_DT_TO_H : ST_DT_TO_L;
            dt_cnt_d   = dt_act_q;
            from_off_d = 1'b1;
          end
        end

        ST_L_ON: begin
          if (raw) begin
            from_off_d = 1'b0;
            if (dt_act_q == '0) begin
              state_d = ST_H_ON;
            end else begin
              state_d  = ST_DT_TO_H;
              dt_cnt_d = dt_act_q;
            end
          end
        end

        ST_H_ON: begin
          if (!raw) begin
            from_off_d = 1'b0;
            if (dt_act_q == '0) begin
              state_d = ST_L_ON;
            end else begin
              state_d  = ST_DT_TO_L;
              dt_cnt_d = dt_act_q;
            end
          end
        end

        ST_DT_TO_H,
        ST_DT_TO_L: begin
          if (!from_off_q && (raw != (state_q == ST_DT_TO_H))) begin
            // Reference reverted: the incoming switch was never turned on, so
            // the outgoing one can be restored without another dead-time.
            state_d  = (state_q == ST_DT_TO_H) ? ST_L_ON : ST_H_ON;
            dt_cnt_d = '0;
          end else begin
            // Coming out of OFF both switches are already off, so the target
            // simply follows raw while the interval keeps running.
            dt_cnt_d = dt_dec;
            if (dt_done) begin
              state_d    = raw ? ST_H_ON : ST_L_ON;
              from_off_d = 1'b0;
            end else begin
              state_d = raw ? ST_DT_TO_H : ST_DT_TO_L;
            end
          end
        end

        default: begin
          state_d    = ST_OFF;
          dt_cnt_d   = '0;
          from_off_d = 1'b0;
        end
      endcase
    end

    // Outputs are decoded from the next state and registered so the gate
    // drivers see clean, glitch-free levels.
    pwm_h_d     = (state_d == ST_H_ON);
    pwm_l_d     = (state_d == ST_L_ON);
    dt_active_d = (state_d == ST_DT_TO_H) || (state_d == ST_DT_TO_L);
  end

  // ---------------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_OFF;
      cmp_act_q   <= '0;
      dt_act_q    <= '0;
      carrier_q   <= '0;
      dt_cnt_q    <= '0;
      from_off_q  <= 1'b0;
      pwm_h_q     <= 1'b0;
      pwm_l_q     <= 1'b0;
      dt_active_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cmp_act_q   <= cmp_act_d;
      dt_act_q    <= dt_act_d;
      carrier_q   <= carrier_d;
      dt_cnt_q    <= dt_cnt_d;
      from_off_q  <= from_off_d;
      pwm_h_q     <= pwm_h_d;
      pwm_l_q     <= pwm_l_d;
      dt_active_q <= dt_active_d;
    end
  end

  assign bus.pwm_h     = pwm_h_q;
  assign bus.pwm_l     = pwm_l_q;
  assign bus.dt_active = dt_active_q;
  // Held low during reset so the pulse never appears while registers clear.
  assign bus.load_evt  = load && !reset;

  // Shoot-through protection: the two gate commands must never overlap, and a
  // dead-time interval always has both switches off.
  a_no_overlap : assert property (@(posedge clk) disable iff (reset)
    !(pwm_h_q && pwm_l_q));
  a_dt_low : assert property (@(posedge clk) disable iff (reset)
    dt_active_q |-> (!pwm_h_q && !pwm_l_q));

endmodule

// File: tb/tb_pwm_compare_dt.sv
module tb_pwm_compare_dt;

  localparam int WIDTH    = 16;
  localparam int DT_WIDTH = 10;
  localparam int PER      = 100;

  logic clk = 1'b1;
  logic reset;

  pwm_compare_dt_if #(.WIDTH(WIDTH), .DT_WIDTH(DT_WIDTH)) bus ();

  pwm_compare_dt #(.WIDTH(WIDTH), .DT_WIDTH(DT_WIDTH)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Reference model: tracks which switch is conducting and how long raw has
  // disagreed with it. A switch-over needs dead-time+1 consecutive samples of
  // disagreement; any agreeing sample cancels the pending switch-over.
  // ---------------------------------------------------------------------------
  logic [WIDTH-1:0]    m_cmp  = '0;
  logic [DT_WIDTH-1:0] m_dt   = '0;
  logic [WIDTH-1:0]    m_carq = '0;
  int  side   = 0;   // 0 none, 1 high-side, 2 low-side
  int  streak = 0;
  int  st_dt  = 0;
  bit  exp_h = 0, exp_l = 0, exp_dta = 0;
  bit  mvalid = 0;

  always @(negedge clk) begin : scoreboard
    logic raw, ld, zev, tev;
    logic [WIDTH-1:0] pm1;
    int want;
    if (mvalid) begin
      chk("pwm_h", bus.pwm_h, exp_h);
      chk("pwm_l", bus.pwm_l, exp_l);
      chk("dt_active", bus.dt_active, exp_dta);
      chk("no_overlap", bus.pwm_h & bus.pwm_l, 0);
    end
    zev = (bus.carrier == '0) && (m_carq != '0);
    pm1 = bus.period - 16'd1;
    tev = 1'b0;
`ifdef PWM_TOP_LOAD_EN
    tev = (bus.carrier >= pm1) && (m_carq < pm1);
`endif
    ld = !reset && bus.pwm_onoff && (zev || tev);
    if (mvalid) chk("load_evt", bus.load_evt, ld);

    if (reset) begin
      m_cmp = '0; m_dt = '0; m_carq = '0;
      side = 0; streak = 0; st_dt = 0;
    end else begin
      raw = (bus.carrier < m_cmp);
      if (!bus.pwm_onoff) begin
        side = 0; streak = 0;
      end else begin
        want = raw ? 1 : 2;
        if (side == want) streak = 0;
        else begin
          if (streak == 0) st_dt = int'(m_dt);
          streak++;
          if (streak > st_dt) begin side = want; streak = 0; end
        end
      end
      if (!bus.pwm_onoff || ld) begin m_cmp = bus.compare; m_dt = bus.deadtime; end
      m_carq = bus.carrier;
    end
    exp_h   = (side == 1) && (streak == 0);
    exp_l   = (side == 2) && (streak == 0);
    exp_dta = (streak > 0);
    mvalid  = 1;
  end

  // ---------------------------------------------------------------------------
  // Stimulus helpers and window counters
  // ---------------------------------------------------------------------------
  int c_h, c_l, c_low, c_dta, c_load, last_load_car;
  int saw_v = 0;

  task automatic clr();
    c_h = 0; c_l = 0; c_low = 0; c_dta = 0; c_load = 0; last_load_car = -1;
  endtask

  // One clock: load_evt sampled before the edge, registered outputs after it.
  task automatic tick();
    @(negedge clk);
    if (bus.load_evt === 1'b1) begin c_load++; last_load_car = int'(bus.carrier); end
    @(posedge clk);
    #1;
    if (bus.pwm_h === 1'b1) c_h++;
    if (bus.pwm_l === 1'b1) c_l++;
    if (bus.pwm_h === 1'b0 && bus.pwm_l === 1'b0) c_low++;
    if (bus.dt_active === 1'b1) c_dta++;
  endtask

  task automatic saw(input int n);
    for (int i = 0; i < n; i++) begin
      bus.carrier = WIDTH'(saw_v);
      saw_v = (saw_v + 1) % PER;
      tick();
    end
  endtask

  task automatic hold(input int car, input int n);
    for (int i = 0; i < n; i++) begin
      bus.carrier = WIDTH'(car);
      tick();
    end
  endtask

  initial begin
`ifdef PWM_TOP_LOAD_EN
    int loads_per = 2;
`else
    int loads_per = 1;
`endif
    clr();
    reset         = 1'b1;
    bus.period    = WIDTH'(PER);
    bus.carrier   = '0;
    bus.compare   = 16'd30;
    bus.deadtime  = 10'd0;
    bus.pwm_onoff = 1'b0;
    repeat (3) tick();
    chk("rst_pwm_h", bus.pwm_h, 0);
    chk("rst_pwm_l", bus.pwm_l, 0);
    chk("rst_dt_active", bus.dt_active, 0);
    reset = 1'b0;
    saw(2);
    chk("off_pwm_h", bus.pwm_h, 0);
    chk("off_pwm_l", bus.pwm_l, 0);

    // Zero dead-time, compare 30.
    bus.pwm_onoff = 1'b1;
    saw(2 * PER - 2);
    clr(); saw(PER);
    chk("d0_h_width", c_h, 30);
    chk("d0_l_width", c_l, 70);
    chk("d0_both_low", c_low, 0);
    chk("d0_loads", c_load, loads_per);
    saw(30);
    chk("d0_lag_h_at29", bus.pwm_h, 1);
    saw(1);
    chk("d0_lag_l_at30", bus.pwm_l, 1);
    saw(PER - 31);

    // Dead-time 5.
    bus.deadtime = 10'd5;
    saw(PER);
    clr(); saw(PER);
    chk("d5_h_width", c_h, 25);
    chk("d5_l_width", c_l, 65);
    chk("d5_both_low", c_low, 10);
    chk("d5_dt_active", c_dta, 10);

    // Shadow write mid-period only takes effect from the next period.
    clr(); saw(51);
    bus.compare = 16'd60;
    saw(PER - 51);
    chk("shadow_h_old", c_h, 25);
    chk("shadow_loads", c_load, loads_per);
`ifdef PWM_TOP_LOAD_EN
    chk("shadow_top_load_car", last_load_car, 99);
`endif
    clr(); saw(PER);
    chk("shadow_h_new", c_h, 55);
    chk("shadow_l_new", c_l, 35);
`ifndef PWM_TOP_LOAD_EN
    chk("shadow_zero_load_car", last_load_car, 0);
`endif

    // Extremes.
    bus.compare = 16'd0;
    saw(PER);
    clr(); saw(PER);
    chk("cmp0_l", c_l, 100);
    chk("cmp0_h", c_h, 0);
    bus.compare = 16'd150;
    saw(PER);
    clr(); saw(PER);
    chk("cmp150_h", c_h, 100);
    chk("cmp150_dt", c_dta, 0);

    // Disable while high, re-enable with raw low and dead-time 5.
    bus.pwm_onoff = 1'b0;
    saw(1);
    chk("dis_h", bus.pwm_h, 0);
    chk("dis_l", bus.pwm_l, 0);
    bus.compare = 16'd0;
    saw(1);
    bus.pwm_onoff = 1'b1;
    clr(); saw(5);
    chk("reen_low", c_low, 5);
    chk("reen_dt", c_dta, 5);
    chk("reen_l_early", c_l, 0);
    saw(1);
    chk("reen_l_on", bus.pwm_l, 1);

    // Two-cycle raw pulse aborts the dead-time and returns to the low side.
    bus.compare = 16'd50;
    saw(PER);
    hold(70, 10);
    clr();
    hold(10, 1);
    hold(11, 1);
    hold(70, 10);
    chk("abort_h", c_h, 0);
    chk("abort_low", c_low, 2);
    chk("abort_l", c_l, 10);

    // Reset in the middle of a dead-time interval.
    hold(10, 1);
    chk("pre_rst_dt", bus.dt_active, 1);
    hold(10, 1);
    reset = 1'b1;
    hold(10, 1);
    chk("mid_rst_h", bus.pwm_h, 0);
    chk("mid_rst_l", bus.pwm_l, 0);
    chk("mid_rst_dt", bus.dt_active, 0);
    reset = 1'b0;
    saw_v = 0;
    saw(2 * PER);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
